branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//   Successor to the combinational ID-stage branch decision. Adds a BHT_DEPTH-entry table of
//   CNT_WIDTH-bit saturating counters, indexed by PC, to predict conditional branches in IF.
//   Resolves each branch in ID against the prediction carried down the pipe and issues the
//   redirect/flush. Trains the table on every resolved branch. Drives the PC-mux select.
// PARAMETERS
//   WIDTH_PC   32  PC width
//   BHT_DEPTH  64  counter entries; must be a power of 2 and >= 2
//   CNT_WIDTH  2   counter bits; must be >= 1
//   INDEX_LSB  2   lowest PC bit used for the index (word-aligned fetch)
// PORTS
//   clk            in   1                clock
//   rst            in   1                reset, synchronous, active-high
//   pc_IF          in   WIDTH_PC         fetch PC
//   br_IF          in   1                predecode: IF instruction is a conditional branch
//   pred_taken_IF  out  1                IF prediction; pipelined externally to pred_taken_ID
//   PCCTRL         in   `WIDTH_PCCTRL    ID control: bits `PCCTRL_B/`PCCTRL_J, cond in [1:0]
//   COMPOut        in   `WIDTH_COMPOUT   comparator: 00 EQ, 01 LT, others GT
//   pc_ID          in   WIDTH_PC         PC of the ID instruction
//   pred_taken_ID  in   1                prediction made for the ID instruction
//   stall_ID       in   1                ID held this cycle
//   PCSel          out  2                00 PC4, 01 JUMP (ID target), 10 PRED (IF target), 11 RECOVER (pc_ID+4)
//   flush          out  1                kill the instruction in IF
// BEHAVIOUR
//   - Index: idx(pc) = pc[INDEX_LSB +: log2(BHT_DEPTH)].
//   - Prediction: pred_taken_IF = br_IF & bht[idx(pc_IF)][CNT_WIDTH-1]. Combinational; 0-cycle latency.
//   - Resolution, ID, combinational:
//     - taken is derived from cond: EQ = (COMPOut==00); NE = !EQ; LT = (COMPOut==01); GE = !LT.
//     - resolve = PCCTRL[`PCCTRL_B] & !stall_ID.
//   - PCSel/flush priority, highest first:
//     - 1. stall_ID: PCSel=PC4, flush=0. No redirect and no training.
//     - 2. PCCTRL[`PCCTRL_J] (jalr, never predicted): PCSel=JUMP, flush=1.
//     - 3. resolve & taken & !pred_taken_ID: PCSel=JUMP, flush=1.
//     - 4. resolve & !taken & pred_taken_ID: PCSel=RECOVER, flush=1.
//     - 5. pred_taken_IF: PCSel=PRED, flush=0.
//     - 6. Otherwise: PCSel=PC4, flush=0.
//     - A correctly predicted branch in ID produces no redirect; the IF prediction then applies.
//   - Training, registered:
//     - On a clk edge with resolve=1, bht[idx(pc_ID)] increments if taken, else decrements.
//     - Saturates at 2^CNT_WIDTH-1 and at 0. Never wraps.
//   - Read/write same index in one cycle: IF sees the pre-update value (no bypass).
//     The new value is visible the next cycle.
//   - Reset:
//     - On the edge with rst=1, every counter loads the weakly-not-taken value 2^(CNT_WIDTH-1)-1.
//       For CNT_WIDTH=1 this is 0.
//     - rst overrides any training update in the same cycle.
//     - Outputs are combinational. After reset, with br_IF=0 and PCCTRL=0: PCSel=PC4,
//       flush=0, pred_taken_IF=0.
//     - rst asserted mid-stream discards all training history.
//   - PCCTRL with both B and J set is illegal. The J rule wins and no training occurs.
// CONFIGURATION
//   BRANCH_PERF_EN defined:
//     - Adds out ports branch_cnt[31:0] and mispred_cnt[31:0].
//     - branch_cnt increments on every resolve. mispred_cnt increments on every resolve
//       with taken != pred_taken_ID.
//     - Both wrap at 2^32 and are cleared by rst.
//   BRANCH_PERF_EN undefined: the ports and counters do not exist. Behaviour above is unchanged.
// TESTING
//   1. rst 1 cycle; br_IF=1, pc_IF=0x100
//      -> pred_taken_IF=0, PCSel=00; every entry reads 01.
//   2. Resolve beq at pc_ID=0x100, COMPOut=00, pred_taken_ID=0
//      -> PCSel=01, flush=1. Next cycle br_IF=1 @0x100 -> pred_taken_IF=1, PCSel=10.
//   3. 4 taken resolves @0x100 -> counter 11. Then bne, COMPOut=00, pred_taken_ID=1
//      -> PCSel=11, flush=1; counter 10, prediction still taken.
//   4. Aliasing: train 0x100 to 11; pc_IF=0x200 (same idx, BHT_DEPTH=64)
//      -> pred_taken_IF=1; 0x104 -> 0.
//   5. stall_ID=1 with a mispredicting bge -> PCSel=00, flush=0, counter unchanged.
//      Same cycle br_IF=1 @ a strongly-taken idx -> PCSel=00.
//   6. jalr with pred_taken_IF=1 -> PCSel=01, flush=1.
//      With BRANCH_PERF_EN: 3 resolves, 1 mispredict -> branch_cnt=3, mispred_cnt=1.
//      rst -> both 0.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and ID-stage resolver: PC-indexed saturating-counter table predicts in IF,
// resolves and trains in ID, drives PCSel/flush. Optional perf counters under BRANCH_PERF_EN.
`ifndef WIDTH_PCCTRL
`define WIDTH_PCCTRL 4
`endif
`ifndef PCCTRL_B
`define PCCTRL_B 3
`endif
`ifndef PCCTRL_J
`define PCCTRL_J 2
`endif
`ifndef WIDTH_COMPOUT
`define WIDTH_COMPOUT 2
`endif

module branch_predict_ctrl #(
  parameter int WIDTH_PC  = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_WIDTH = 2,
  parameter int INDEX_LSB = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_PC-1:0]       pc_IF,
  input  logic                      br_IF,
  output logic                      pred_taken_IF,
  input  logic [`WIDTH_PCCTRL-1:0]  PCCTRL,
  input  logic [`WIDTH_COMPOUT-1:0] COMPOut,
  input  logic [WIDTH_PC-1:0]       pc_ID,
  input  logic                      pred_taken_ID,
  input  logic                      stall_ID,
  output logic [1:0]                PCSel,
  output logic                      flush
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]               branch_cnt,
  output logic [31:0]               mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int WNT_INT = (2 ** (CNT_WIDTH - 1)) - 1;
  localparam int ONE_INT = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = WNT_INT[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = ONE_INT[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = '0;

  localparam logic [1:0] PCSEL_PC4     = 2'b00;
  localparam logic [1:0] PCSEL_JUMP    = 2'b01;
  localparam logic [1:0] PCSEL_PRED    = 2'b10;
  localparam logic [1:0] PCSEL_RECOVER = 2'b11;

  logic [CNT_WIDTH-1:0] bht [BHT_DEPTH];
  logic [IDX_W-1:0]     idx_if;
  logic [IDX_W-1:0]     idx_id;
  logic                 is_b;
  logic                 is_j;
  logic                 eq;
  logic                 lt;
  logic                 taken;
  logic                 resolve;
  logic                 train_en;

  assign idx_if = pc_IF[INDEX_LSB +: IDX_W];
  assign idx_id = pc_ID[INDEX_LSB +: IDX_W];
  assign is_b   = PCCTRL[`PCCTRL_B];
  assign is_j   = PCCTRL[`PCCTRL_J];
  assign eq     = (COMPOut == `WIDTH_COMPOUT'(0));
  assign lt     = (COMPOut == `WIDTH_COMPOUT'(1));

  // Low PC bits below the index and above it never affect the table; collected to keep lint quiet.
  logic unused_bits;
  assign unused_bits = &{1'b0, pc_IF, pc_ID, PCCTRL};

  always_comb begin
    taken = 1'b0;
    case (PCCTRL[1:0])
      2'b00:   taken = eq;
      2'b01:   taken = !eq;
      2'b10:   taken = lt;
      default: taken = !lt;
    endcase
  end

  assign resolve       = is_b & !stall_ID;
  // An illegal B+J encoding is treated as a jump: no training and no perf counting.
  assign train_en      = resolve & !is_j;
  assign pred_taken_IF = br_IF & bht[idx_if][CNT_WIDTH-1];

  always_comb begin
    PCSel = PCSEL_PC4;
    flush = 1'b0;
    if (stall_ID) begin
      PCSel = PCSEL_PC4;
      flush = 1'b0;
    end else if (is_j) begin
      PCSel = PCSEL_JUMP;
      flush = 1'b1;
    end else if (resolve && taken && !pred_taken_ID) begin
      PCSel = PCSEL_JUMP;
      flush = 1'b1;
    end else if (resolve && !taken && pred_taken_ID) begin
      PCSel = PCSEL_RECOVER;
      flush = 1'b1;
    end else if (pred_taken_IF) begin
      PCSel = PCSEL_PRED;
      flush = 1'b0;
    end
  end

  // No write-to-read bypass: IF reads the pre-update counter in the training cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CNT_WNT;
      end
    end else if (train_en) begin
      if (taken) begin
        if (bht[idx_id] != CNT_MAX) bht[idx_id] <= bht[idx_id] + CNT_ONE;
      end else begin
        if (bht[idx_id] != CNT_MIN) bht[idx_id] <= bht[idx_id] - CNT_ONE;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (train_en) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (taken != pred_taken_ID) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: prediction, resolution priority, training,
// saturation, aliasing, stall, jalr, reset; perf counters when BRANCH_PERF_EN is defined.
module tb_branch_predict_ctrl;

  localparam logic [3:0] BEQ  = 4'b1000;
  localparam logic [3:0] BNE  = 4'b1001;
  localparam logic [3:0] BLT  = 4'b1010;
  localparam logic [3:0] BGE  = 4'b1011;
  localparam logic [3:0] JALR = 4'b0100;
  localparam logic [3:0] BJ   = 4'b1100;

  logic        clk;
  logic        rst;
  logic [31:0] pc_IF;
  logic        br_IF;
  logic        pred_taken_IF;
  logic [3:0]  PCCTRL;
  logic [1:0]  COMPOut;
  logic [31:0] pc_ID;
  logic        pred_taken_ID;
  logic        stall_ID;
  logic [1:0]  PCSel;
  logic        flush;
`ifdef BRANCH_PERF_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
`endif

  int errors = 0;
  int checks = 0;

  branch_predict_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_IF         (pc_IF),
    .br_IF         (br_IF),
    .pred_taken_IF (pred_taken_IF),
    .PCCTRL        (PCCTRL),
    .COMPOut       (COMPOut),
    .pc_ID         (pc_ID),
    .pred_taken_ID (pred_taken_ID),
    .stall_ID      (stall_ID),
    .PCSel         (PCSel),
    .flush         (flush)
`ifdef BRANCH_PERF_EN
    ,
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic [3:0] ctrl, input logic [1:0] comp,
                        input logic [31:0] pc, input logic pred);
    PCCTRL        = ctrl;
    COMPOut       = comp;
    pc_ID         = pc;
    pred_taken_ID = pred;
    #1;
  endtask

  task automatic id_clear();
    id_set(4'b0000, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic if_set(input logic br, input logic [31:0] pc);
    br_IF = br;
    pc_IF = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_ID = 1'b0;
    br_IF = 1'b0; pc_IF = 32'h0;
    PCCTRL = 4'b0; COMPOut = 2'b0; pc_ID = 32'h0; pred_taken_ID = 1'b0;

    // Reset: every counter weakly not-taken.
    tick();
    rst = 1'b0;
    if_set(1'b1, 32'h100);
    chk("rst_pred", pred_taken_IF, 0);
    chk("rst_pcsel", PCSel, 2'b00);
    chk("rst_flush", flush, 0);
    if_set(1'b1, 32'h104);
    chk("rst_pred_104", pred_taken_IF, 0);

    // Mispredicted taken beq; IF sees the pre-update counter in the same cycle.
    if_set(1'b1, 32'h100);
    id_set(BEQ, 2'b00, 32'h100, 1'b0);
    chk("beq_jump_pcsel", PCSel, 2'b01);
    chk("beq_jump_flush", flush, 1);
    chk("no_bypass_pred", pred_taken_IF, 0);
    tick();
    id_clear();
    chk("trained_pred", pred_taken_IF, 1);
    chk("trained_pcsel", PCSel, 2'b10);
    chk("trained_flush", flush, 0);

    // Correctly predicted taken branches; counter saturates at 11.
    if_set(1'b0, 32'h100);
    id_set(BEQ, 2'b00, 32'h100, 1'b1);
    chk("correct_pred_pcsel", PCSel, 2'b00);
    chk("correct_pred_flush", flush, 0);
    repeat (4) tick();
    id_set(BNE, 2'b00, 32'h100, 1'b1);
    chk("bne_recover_pcsel", PCSel, 2'b11);
    chk("bne_recover_flush", flush, 1);
    tick();
    id_clear();
    if_set(1'b1, 32'h100);
    chk("sat_hi_pred", pred_taken_IF, 1);
    id_set(BEQ, 2'b01, 32'h100, 1'b1);
    chk("recover_over_pred", PCSel, 2'b11);
    tick();
    id_clear();
    chk("after_two_dec_pred", pred_taken_IF, 0);

    // Aliasing: 0x200 shares index 0 with 0x100.
    id_set(BEQ, 2'b00, 32'h100, 1'b0);
    tick();
    tick();
    id_clear();
    if_set(1'b1, 32'h200);
    chk("alias_pred", pred_taken_IF, 1);
    chk("alias_pcsel", PCSel, 2'b10);
    if_set(1'b1, 32'h104);
    chk("other_idx_pred", pred_taken_IF, 0);
    chk("other_idx_pcsel", PCSel, 2'b00);

    // Stalled mispredicting bge: no redirect, no training, PRED suppressed.
    stall_ID = 1'b1;
    if_set(1'b1, 32'h100);
    id_set(BGE, 2'b01, 32'h100, 1'b1);
    chk("stall_pcsel", PCSel, 2'b00);
    chk("stall_flush", flush, 0);
    tick();
    tick();
    stall_ID = 1'b0;
    id_set(BGE, 2'b01, 32'h100, 1'b1);
    chk("bge_nt_recover", PCSel, 2'b11);
    tick();
    id_clear();
    chk("stall_no_train_pred", pred_taken_IF, 1);

    // LT/GE decoding (combinational only, no edges).
    id_set(BLT, 2'b01, 32'h108, 1'b0);
    chk("blt_taken", PCSel, 2'b01);
    id_set(BGE, 2'b10, 32'h108, 1'b0);
    chk("bge_gt_taken", PCSel, 2'b01);
    id_set(BLT, 2'b10, 32'h108, 1'b1);
    chk("blt_gt_recover", PCSel, 2'b11);
    id_set(BNE, 2'b11, 32'h108, 1'b0);
    chk("bne_gt_taken", PCSel, 2'b01);
    id_clear();

    // Decrement saturates at 0.
    if_set(1'b0, 32'h0);
    id_set(BEQ, 2'b01, 32'h10C, 1'b0);
    chk("correct_nt_pcsel", PCSel, 2'b00);
    repeat (3) tick();
    id_clear();
    if_set(1'b1, 32'h10C);
    chk("sat_lo_pred", pred_taken_IF, 0);
    id_set(BEQ, 2'b00, 32'h10C, 1'b0);
    tick();
    id_clear();
    chk("sat_lo_then_inc_pred", pred_taken_IF, 0);

    // jalr wins over IF prediction; illegal B+J acts as jump without training.
    if_set(1'b1, 32'h100);
    id_set(JALR, 2'b00, 32'h0, 1'b0);
    chk("jalr_pcsel", PCSel, 2'b01);
    chk("jalr_flush", flush, 1);
    id_set(BJ, 2'b00, 32'h110, 1'b0);
    chk("bj_pcsel", PCSel, 2'b01);
    chk("bj_flush", flush, 1);
    tick();
    id_clear();
    if_set(1'b1, 32'h110);
    chk("bj_no_train", pred_taken_IF, 0);

    // Mid-stream reset discards history and overrides a concurrent update.
    id_set(BEQ, 2'b00, 32'h110, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_clear();
    if_set(1'b1, 32'h100);
    chk("rst2_pred_100", pred_taken_IF, 0);
    chk("rst2_pcsel", PCSel, 2'b00);
    if_set(1'b1, 32'h110);
    chk("rst2_pred_110", pred_taken_IF, 0);

`ifdef BRANCH_PERF_EN
    chk("perf_br_rst", branch_cnt, 0);
    chk("perf_mp_rst", mispred_cnt, 0);
    id_set(BEQ, 2'b00, 32'h120, 1'b1);
    tick();
    id_set(BEQ, 2'b01, 32'h120, 1'b0);
    tick();
    id_set(BNE, 2'b00, 32'h120, 1'b1);
    tick();
    stall_ID = 1'b1;
    id_set(BNE, 2'b00, 32'h120, 1'b1);
    tick();
    stall_ID = 1'b0;
    id_set(JALR, 2'b00, 32'h120, 1'b0);
    tick();
    id_clear();
    chk("perf_br_cnt", branch_cnt, 3);
    chk("perf_mp_cnt", mispred_cnt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("perf_br_clr", branch_cnt, 0);
    chk("perf_mp_clr", mispred_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
